fifo_reader: RTL and testbench

//  Read-side master for the FIFO. Pulls words through rd_en and absorbs the FIFO's 1-cycle read latency.
//  Re-presents the data as a valid/ready stream to downstream logic.

---
 rtl/fifo_reader.sv | 125 ++++++++++++
 tb/tb_fifo_reader.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// fifo_reader: read-side master for the FIFO. It issues rd_en, absorbs the
// FIFO's one-cycle read latency in a 2-entry skid buffer, and presents the
// words as a valid/ready stream. It also supports a flush (drain-to-empty)
// command.
// Optional build macro: READER_PROTO_CHK_EN adds a sticky protocol error output `err`.
module fifo_reader #(
  parameter int unsigned FIFO_WIDTH    = 16,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned max_fifo_addr = $clog2(FIFO_DEPTH),
  parameter int unsigned CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     flush,
  input  logic                     empty,
  input  logic [max_fifo_addr:0]   count,
  input  logic                     underflow,
  input  logic [FIFO_WIDTH-1:0]    data_out,
  output logic                     rd_en,
  output logic [FIFO_WIDTH-1:0]    m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     busy,
  output logic                     drain_done,
  output logic [CNT_W-1:0]         words_read
`ifdef READER_PROTO_CHK_EN
  ,
  output logic                     err
`endif
);

  typedef enum logic [1:0] {IDLE, STREAM, STOP, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [FIFO_WIDTH-1:0]   skid [2];
  logic [1:0]              buf_cnt;
  logic                    rd_pend;
  logic                    pop;
  logic [1:0]              occ_after;
  logic                    tail;

  // Stream side is driven straight from the skid buffer registers.
  assign m_valid = (buf_cnt != 2'd0);
  assign m_data  = skid[0];
  assign pop     = m_valid && m_ready;
  assign busy    = (state != IDLE) || (buf_cnt != 2'd0) || rd_pend;

  // Occupancy after this edge excluding a new read; a read only fits below 2.
  assign occ_after = buf_cnt + 2'(rd_pend) - 2'(pop);
  assign tail      = 1'(buf_cnt - 2'(pop));
  assign rd_en     = ((state == STREAM) || (state == DRAIN)) && !empty &&
                     (occ_after < 2'd2);

  // Next-state logic and the drain completion pulse.
  always_comb begin
    state_nxt  = state;
    drain_done = 1'b0;
    case (state)
      IDLE: begin
        if (flush)       state_nxt = DRAIN;
        else if (enable) state_nxt = STREAM;
      end
      STREAM: begin
        if (flush)        state_nxt = DRAIN;
        else if (!enable) state_nxt = STOP;
      end
      STOP: begin
        if (!rd_pend) state_nxt = IDLE;
      end
      DRAIN: begin
        if (empty && !rd_pend &&
            ((buf_cnt == 2'd0) || ((buf_cnt == 2'd1) && pop))) begin
          state_nxt  = IDLE;
          drain_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, skid buffer, in-flight read flag and delivered-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      buf_cnt    <= 2'd0;
      rd_pend    <= 1'b0;
      skid[0]    <= '0;
      skid[1]    <= '0;
      words_read <= '0;
    end else begin
      state   <= state_nxt;
      rd_pend <= rd_en;
      buf_cnt <= occ_after;
      if (pop) begin
        skid[0]    <= skid[1];
        words_read <= words_read + CNT_W'(1);
      end
      if (rd_pend) skid[tail] <= data_out;
    end
  end

`ifdef READER_PROTO_CHK_EN
  logic pend_empty;
  logic unused_count;

  assign unused_count = ^count;

  // Sticky error on FIFO underflow or on capturing a read issued against an empty FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_empty <= 1'b0;
      err        <= 1'b0;
    end else begin
      pend_empty <= rd_en && empty;
      if (underflow || (rd_pend && pend_empty)) err <= 1'b1;
    end
  end
`else
  logic unused_inputs;

  assign unused_inputs = ^{count, underflow};
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Testbench for fifo_reader: behavioural FIFO model plus an in-order scoreboard.
module tb_fifo_reader;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst, enable, flush, empty, underflow, rd_en;
  logic          m_valid, m_ready, busy, drain_done;
  logic [3:0]    count;
  logic [W-1:0]  data_out, m_data;
  logic [15:0]   words_read;
`ifdef READER_PROTO_CHK_EN
  logic          err;
`endif

  always #5 clk = ~clk;

  fifo_reader dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .empty(empty),
    .count(count), .underflow(underflow), .data_out(data_out), .rd_en(rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
    .drain_done(drain_done), .words_read(words_read)
`ifdef READER_PROTO_CHK_EN
    , .err(err)
`endif
  );

  // FIFO model: depth 8, one-cycle read latency
  logic [W-1:0] mem [8];
  logic [2:0]   wp, rp;
  logic [3:0]   n;
  logic         push_en, fifo_clr, uf_r, uf_force;
  logic [W-1:0] push_data;

  assign empty     = (n == 4'd0);
  assign count     = n;
  assign underflow = uf_r | uf_force;

  always @(posedge clk) begin
    if (fifo_clr) begin
      wp <= '0; rp <= '0; n <= '0; uf_r <= 1'b0;
    end else begin
      uf_r <= rd_en && (n == 4'd0);
      if (push_en) begin
        mem[wp] <= push_data;
        wp <= wp + 3'd1;
      end
      if (rd_en && (n != 4'd0)) begin
        data_out <= mem[rp];
        rp <= rp + 3'd1;
      end
      n <= n + 4'(push_en) - 4'(rd_en && (n != 4'd0));
    end
  end

  // Scoreboard and bookkeeping
  logic [W-1:0] exp_q [$];
  int errors = 0, checks = 0;
  int cyc = 0, rds = 0, pops = 0, dds = 0, words_exp = 0;
  int first_rd = -1, last_rd = -1, first_v = -1, first_pop = -1, last_pop = -1;
  bit dd_ok = 0;

  // One clock cycle: evaluate handshakes with final inputs, then advance.
  task automatic tick;
    logic stall;
    logic hs;
    logic [W-1:0] hold, e;
    #1;
    if (!rst) begin
      hs = m_valid && m_ready;
      if (rd_en) begin
        rds++; last_rd = cyc;
        if (first_rd < 0) first_rd = cyc;
        checks++;
        if (empty) begin
          errors++;
          $display("FAIL rd_en_while_empty: rd_en=1 with empty=1, required rd_en=0");
        end
      end
      if (m_valid && first_v < 0) first_v = cyc;
      if (hs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h, required no word", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            errors++;
            $display("FAIL stream_order: got %h, required %h", m_data, e);
          end
        end
        pops++; words_exp++; last_pop = cyc;
        if (first_pop < 0) first_pop = cyc;
      end
      if (drain_done) begin
        dds++;
        if (hs && exp_q.size() == 0) dd_ok = 1;
      end
    end
    stall = m_valid && !m_ready && !rst;
    hold  = m_data;
    @(negedge clk); #1;
    cyc++;
    if (stall) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== hold) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b data=%h, required valid=1 data=%h", m_valid, m_data, hold);
      end
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    push_en = 1'b1; push_data = w; exp_q.push_back(w);
    tick();
    push_en = 1'b0;
  endtask

  task automatic clear_stats;
    rds = 0; pops = 0; dds = 0; dd_ok = 0;
    first_rd = -1; last_rd = -1; first_v = -1; first_pop = -1; last_pop = -1;
  endtask

  task automatic drain_to_idle;
    int k;
    enable = 1'b0; flush = 1'b0; m_ready = 1'b1;
    k = 0;
    while (busy && k < 40) begin tick(); k++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; fifo_clr = 1'b1;
    tick(); tick();
    rst = 1'b0; fifo_clr = 1'b0;
    checks++;
    if (rd_en !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || busy !== 1'b0 ||
        drain_done !== 1'b0 || words_read !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: rd_en=%b m_valid=%b m_data=%h busy=%b drain_done=%b words_read=%0d, required all 0",
               rd_en, m_valid, m_data, busy, drain_done, words_read);
    end
`ifdef READER_PROTO_CHK_EN
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: err=%b, required 0", err);
    end
`endif
  endtask

  task automatic test_stream;
    for (int i = 0; i < 4; i++) push_word(W'(16'hA000 + i));
    clear_stats();
    m_ready = 1'b1; enable = 1'b1;
    repeat (10) tick();
    checks++;
    if (rds != 4 || last_rd - first_rd != 3) begin
      errors++;
      $display("FAIL stream_reads: got %0d reads over span %0d, required 4 over span 3", rds, last_rd - first_rd);
    end
    checks++;
    if (first_v != first_rd + 2) begin
      errors++;
      $display("FAIL stream_latency: first valid at %0d, required %0d", first_v, first_rd + 2);
    end
    checks++;
    if (pops != 4 || last_pop - first_pop != 3) begin
      errors++;
      $display("FAIL stream_throughput: got %0d pops over span %0d, required 4 over span 3", pops, last_pop - first_pop);
    end
    checks++;
    if (words_read !== 16'(words_exp)) begin
      errors++;
      $display("FAIL stream_words_read: got %0d, required %0d", words_read, words_exp);
    end
    drain_to_idle();
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 6; i++) push_word(W'(16'hF000 + 16'h0011 * i));
    clear_stats();
    m_ready = 1'b0; enable = 1'b1;
    repeat (10) tick();
    checks++;
    if (rds != 2) begin
      errors++;
      $display("FAIL stall_reads: got %0d reads, required 2", rds);
    end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 16'hF000) begin
      errors++;
      $display("FAIL stall_head: got valid=%b data=%h, required valid=1 data=f000", m_valid, m_data);
    end
    m_ready = 1'b1;
    repeat (12) tick();
    checks++;
    if (pops != 6 || exp_q.size() != 0 || rds != 6) begin
      errors++;
      $display("FAIL stall_release: got pops=%0d reads=%0d left=%0d, required 6 6 0", pops, rds, exp_q.size());
    end
    checks++;
    if (words_read !== 16'(words_exp)) begin
      errors++;
      $display("FAIL stall_words_read: got %0d, required %0d", words_read, words_exp);
    end
    drain_to_idle();
  endtask

  task automatic test_flush;
    int k;
    for (int i = 0; i < 3; i++) push_word(W'(16'h5A00 + i));
    clear_stats();
    m_ready = 1'b1; enable = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    k = 0;
    while (dds == 0 && k < 20) begin tick(); k++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: busy=%b after drain_done, required 0", busy);
    end
    checks++;
    if (!dd_ok || rds != 3 || pops != 3) begin
      errors++;
      $display("FAIL flush_drain: got dd_on_last=%0d reads=%0d pops=%0d, required 1 3 3", dd_ok, rds, pops);
    end
    repeat (5) tick();
    checks++;
    if (dds != 1) begin
      errors++;
      $display("FAIL flush_pulse_count: got %0d pulses, required 1", dds);
    end
  endtask

  task automatic test_flush_priority;
    int k;
    for (int i = 0; i < 2; i++) push_word(W'(16'h7700 + i));
    clear_stats();
    m_ready = 1'b1; enable = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    k = 0;
    while (dds == 0 && k < 20) begin tick(); k++; end
    checks++;
    if (dds != 1 || !dd_ok || pops != 2) begin
      errors++;
      $display("FAIL flush_priority: got pulses=%0d dd_on_last=%0d pops=%0d, required 1 1 2", dds, dd_ok, pops);
    end
    drain_to_idle();
  endtask

  task automatic test_empty_enable;
    bit mv_seen = 0, uf_seen = 0;
    clear_stats();
    enable = 1'b1; m_ready = 1'b1;
    repeat (20) begin
      tick();
      if (m_valid) mv_seen = 1;
      if (underflow) uf_seen = 1;
    end
    checks++;
    if (rds != 0 || mv_seen || uf_seen) begin
      errors++;
      $display("FAIL empty_enable: got reads=%0d valid_seen=%0d underflow_seen=%0d, required 0 0 0", rds, mv_seen, uf_seen);
    end
    drain_to_idle();
  endtask

  task automatic test_reset_midstream;
    bit mv_seen = 0;
    for (int i = 0; i < 6; i++) push_word(W'(16'hC000 + i));
    clear_stats();
    m_ready = 1'b1; enable = 1'b1;
    repeat (4) tick();
    rst = 1'b1; fifo_clr = 1'b1;
    tick();
    rst = 1'b0; fifo_clr = 1'b0; enable = 1'b0;
    exp_q.delete(); words_exp = 0;
    checks++;
    if (rd_en !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || busy !== 1'b0 ||
        drain_done !== 1'b0 || words_read !== 16'd0) begin
      errors++;
      $display("FAIL midstream_reset: rd_en=%b m_valid=%b m_data=%h busy=%b drain_done=%b words_read=%0d, required all 0",
               rd_en, m_valid, m_data, busy, drain_done, words_read);
    end
    repeat (6) begin
      tick();
      if (m_valid) mv_seen = 1;
    end
    checks++;
    if (mv_seen) begin
      errors++;
      $display("FAIL stale_word: m_valid seen after reset, required none");
    end
  endtask

`ifdef READER_PROTO_CHK_EN
  task automatic test_err;
    uf_force = 1'b1;
    tick();
    uf_force = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: err=%b, required 1", err);
    end
    repeat (5) tick();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%b, required 1", err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%b, required 0", err);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; enable = 1'b0; flush = 1'b0; m_ready = 1'b0;
    push_en = 1'b0; push_data = '0; fifo_clr = 1'b1; uf_force = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_flush_priority();
    test_empty_enable();
    test_reset_midstream();
`ifdef READER_PROTO_CHK_EN
    test_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
